// File: rtl/stage_m_mc_if.sv
// Memory-stage bus: pipeline operands in, load data / writeback / stall / error out.
// The master side is the pipeline (or a bench); the slave side is stage_m_mc.
interface stage_m_mc_if;
    logic [31:0] PC_M;
    logic        MemRd_M;
    logic        MemWr_M;
    logic [1:0]  MemSize_M;
    logic        MemSign_M;
    logic [31:0] A_M;
    logic [31:0] WD_M;
    logic [31:0] RFWD_W;
    logic        MF_DMWD_Sel;
    logic [1:0]  WDSel_M;
    logic [31:0] C_M;
    logic [31:0] PC8_M;
    logic [31:0] D_M;
    logic [31:0] RFWD_M;
    logic        stall_M;
    logic        addr_err_M;

    modport master (
        output PC_M, MemRd_M, MemWr_M, MemSize_M, MemSign_M, A_M, WD_M,
               RFWD_W, MF_DMWD_Sel, WDSel_M, C_M, PC8_M,
        input  D_M, RFWD_M, stall_M, addr_err_M
    );

    modport slave (
        input  PC_M, MemRd_M, MemWr_M, MemSize_M, MemSign_M, A_M, WD_M,
               RFWD_W, MF_DMWD_Sel, WDSel_M, C_M, PC8_M,
        output D_M, RFWD_M, stall_M, addr_err_M
    );
endinterface

// File: rtl/stage_m_mc.sv
// Pipeline M stage with a multi-cycle data memory: LAT-cycle stall per access,
// byte/half/word lanes, alignment and range checking, and writeback selection.
module stage_m_mc #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    stage_m_mc_if.slave  bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam bit         HAS_LAT  = (LAT > 0);
    localparam logic [2:0] CNT_INIT = HAS_LAT ? 3'(LAT - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t       r_state, w_state_next;
    logic [2:0]   r_cnt, w_cnt_next;
    logic [AW-1:0] r_addr;
    logic [1:0]   r_off, r_size;
    logic         r_sign, r_wr;
    logic [31:0]  r_wd;

    logic          w_req, w_is_word, w_is_half, w_misalign, w_range_err, w_err, w_ok;
    logic          w_wr_req, w_stall, w_we, w_ld_fire;
    logic [31:0]   w_sd, w_wdata, w_lane_data, w_rword, w_ld_data, w_d;
    logic [AW-1:0] w_idx, w_waddr, w_raddr;
    logic [1:0]    w_wsize, w_woff, w_lsize, w_loff;
    logic          w_lsign;
    logic [3:0]    w_be;
    logic          w_unused;

    // PC_M travels with the instruction for tracing only.
    assign w_unused = ^bus.PC_M;

    assign w_req       = (r_state == S_IDLE) && (bus.MemRd_M || bus.MemWr_M);
    assign w_is_word   = (bus.MemSize_M == 2'b00) || (bus.MemSize_M == 2'b11);
    assign w_is_half   = (bus.MemSize_M == 2'b01);
    assign w_misalign  = (w_is_word && (bus.A_M[1:0] != 2'b00)) || (w_is_half && bus.A_M[0]);
    assign w_range_err = {2'b00, bus.A_M[31:2]} >= 32'(DEPTH);
    assign w_err       = w_req && (w_misalign || w_range_err);
    assign w_ok        = w_req && !w_err;
    // A simultaneous read+write request resolves to a store.
    assign w_wr_req    = bus.MemWr_M;
    assign w_sd        = bus.MF_DMWD_Sel ? bus.RFWD_W : bus.WD_M;
    assign w_idx       = bus.A_M[AW+1:2];

    // State register, latency counter and operand latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_wr    <= 1'b0;
            r_wd    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (HAS_LAT && w_ok) begin
                r_addr <= w_idx;
                r_off  <= bus.A_M[1:0];
                r_size <= bus.MemSize_M;
                r_sign <= bus.MemSign_M;
                r_wr   <= w_wr_req;
                r_wd   <= w_sd;
            end
        end
    end

    // The acceptance cycle is the first stall cycle, so WAIT spans the
    // remaining LAT-1 cycles and DONE is entered once the counter drains to 0.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (HAS_LAT && w_ok) begin
                    w_cnt_next   = CNT_INIT;
                    w_state_next = (CNT_INIT == 3'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                if (w_cnt_next == 3'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_cnt_next   = 3'd0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_cnt_next   = 3'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode: stall, memory write strobe and load completion.
    always_comb begin
        w_stall   = 1'b0;
        w_we      = 1'b0;
        w_ld_fire = 1'b0;
        w_waddr   = r_addr;
        w_wsize   = r_size;
        w_woff    = r_off;
        w_wdata   = r_wd;
        w_raddr   = r_addr;
        w_lsize   = r_size;
        w_loff    = r_off;
        w_lsign   = r_sign;
        case (r_state)
            S_IDLE: begin
                w_stall = HAS_LAT && w_ok;
                if (!HAS_LAT && w_ok) begin
                    w_we      = w_wr_req;
                    w_ld_fire = !w_wr_req;
                    w_waddr   = w_idx;
                    w_wsize   = bus.MemSize_M;
                    w_woff    = bus.A_M[1:0];
                    w_wdata   = w_sd;
                    w_raddr   = w_idx;
                    w_lsize   = bus.MemSize_M;
                    w_loff    = bus.A_M[1:0];
                    w_lsign   = bus.MemSign_M;
                end
            end
            S_WAIT: w_stall = 1'b1;
            S_DONE: begin
                w_we      = r_wr;
                w_ld_fire = !r_wr;
            end
            default: w_stall = 1'b0;
        endcase
    end

    // Store lanes: data is replicated so each byte lane sees its own slice.
    always_comb begin
        case (w_wsize)
            2'b01: begin
                w_be        = w_woff[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_be        = 4'b0001 << w_woff;
                w_lane_data = {4{w_wdata[7:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_lane_data = w_wdata;
            end
        endcase
    end

    // One byte-wide array per lane; the whole memory clears on reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_lane[i] <= 8'h00;
                    end
                end else if (w_we && w_be[gi]) begin
                    r_lane[w_waddr] <= w_lane_data[8*gi +: 8];
                end
            end
            assign w_rword[8*gi +: 8] = r_lane[w_raddr];
        end
    endgenerate

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sign);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? word[31:16] : word[15:0];
        b = 8'(word >> {off, 3'b000});
        case (size)
            2'b01:   return sign ? {{16{h[15]}}, h} : {16'h0000, h};
            2'b10:   return sign ? {{24{b[7]}}, b} : {24'h000000, b};
            default: return word;
        endcase
    endfunction

    assign w_ld_data = f_extract(w_rword, w_loff, w_lsize, w_lsign);
    assign w_d       = w_ld_fire ? w_ld_data : 32'h0;

    assign bus.D_M        = w_d;
    assign bus.stall_M    = w_stall;
    assign bus.addr_err_M = w_err;

    always_comb begin
        case (bus.WDSel_M)
            2'b00:   bus.RFWD_M = bus.C_M;
            2'b01:   bus.RFWD_M = w_d;
            2'b10:   bus.RFWD_M = bus.PC8_M;
            default: bus.RFWD_M = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_stage_m_mc.sv
// Bench for stage_m_mc: a LAT=2 and a LAT=0 instance checked against a
// byte-addressed reference memory with directed and random accesses.
module tb_stage_m_mc;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mdl [2][DEPTH*4];

    stage_m_mc_if ifa();
    stage_m_mc_if ifb();

    stage_m_mc #(.DEPTH(DEPTH), .LAT(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    stage_m_mc #(.DEPTH(DEPTH), .LAT(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic mdl_err(input logic [1:0] sz, input logic [31:0] a);
        logic is_word;
        is_word = (sz == 2'b00) || (sz == 2'b11);
        return (is_word && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]) || (a[31:2] >= 30'(DEPTH));
    endfunction

    function automatic logic [31:0] mdl_load(input int w, input logic [1:0] sz, input logic sgn,
                                             input logic [31:0] a);
        int b;
        logic [15:0] h;
        b = int'(a[15:0]);
        case (sz)
            2'b01: begin
                h = {mdl[w][b+1], mdl[w][b]};
                return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            end
            2'b10: return sgn ? {{24{mdl[w][b][7]}}, mdl[w][b]} : {24'h0, mdl[w][b]};
            default: return {mdl[w][b+3], mdl[w][b+2], mdl[w][b+1], mdl[w][b]};
        endcase
    endfunction

    task automatic mdl_store(input int w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
        int b;
        b = int'(a[15:0]);
        case (sz)
            2'b01: begin mdl[w][b] = d[7:0]; mdl[w][b+1] = d[15:8]; end
            2'b10: mdl[w][b] = d[7:0];
            default: for (int k = 0; k < 4; k++) mdl[w][b+k] = d[8*k +: 8];
        endcase
    endtask

    task automatic mdl_clear();
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < DEPTH*4; k++) mdl[w][k] = 8'h00;
    endtask

    function automatic logic [31:0] exp_rfwd(input logic [1:0] sel, input logic [31:0] c,
                                             input logic [31:0] d, input logic [31:0] p);
        case (sel)
            2'b00: return c;
            2'b01: return d;
            2'b10: return p;
            default: return 32'h0;
        endcase
    endfunction

    // One access on the LAT=2 instance; returns D_M seen in the completion cycle.
    task automatic acc_a(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rfwd, input logic sel, output logic [31:0] dobs);
        logic err;
        logic [31:0] exp_d, sd;
        int cyc;
        @(negedge clk);
        ifa.MemRd_M = rd; ifa.MemWr_M = wr; ifa.MemSize_M = sz; ifa.MemSign_M = sgn;
        ifa.A_M = a; ifa.WD_M = wd; ifa.RFWD_W = rfwd; ifa.MF_DMWD_Sel = sel;
        ifa.WDSel_M = 2'($urandom_range(0, 3)); ifa.C_M = $urandom; ifa.PC8_M = $urandom;
        ifa.PC_M = $urandom;
        err = mdl_err(sz, a);
        sd = sel ? rfwd : wd;
        #1;
        chk({tag, ".err"}, {31'b0, ifa.addr_err_M}, {31'b0, err});
        if (err) begin
            chk({tag, ".stall"}, {31'b0, ifa.stall_M}, 32'h0);
            chk({tag, ".d"}, ifa.D_M, 32'h0);
            dobs = ifa.D_M;
        end else begin
            cyc = 0;
            while (ifa.stall_M === 1'b1 && cyc < 20) begin
                cyc++;
                @(posedge clk);
                #1;
                ifa.A_M = $urandom; ifa.WD_M = $urandom; ifa.RFWD_W = $urandom;
                ifa.MemSize_M = 2'($urandom_range(0, 3)); ifa.MemSign_M = 1'($urandom_range(0, 1));
            end
            chk({tag, ".stall_cycles"}, 32'(cyc), 32'd2);
            exp_d = (rd && !wr) ? mdl_load(0, sz, sgn, a) : 32'h0;
            chk({tag, ".d"}, ifa.D_M, exp_d);
            chk({tag, ".rfwd"}, ifa.RFWD_M, exp_rfwd(ifa.WDSel_M, ifa.C_M, exp_d, ifa.PC8_M));
            dobs = ifa.D_M;
            if (wr) mdl_store(0, sz, a, sd);
        end
        $display("A %s rd=%0b wr=%0b sz=%0d a=%h sd=%h err=%0b D_M=%h", tag, rd, wr, sz, a, sd, err, dobs);
        @(negedge clk);
        ifa.MemRd_M = 1'b0; ifa.MemWr_M = 1'b0;
    endtask

    // One access on the LAT=0 instance; consecutive calls give back-to-back requests.
    task automatic acc_b(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rfwd, input logic sel, output logic [31:0] dobs);
        logic err;
        logic [31:0] exp_d;
        @(negedge clk);
        ifb.MemRd_M = rd; ifb.MemWr_M = wr; ifb.MemSize_M = sz; ifb.MemSign_M = sgn;
        ifb.A_M = a; ifb.WD_M = wd; ifb.RFWD_W = rfwd; ifb.MF_DMWD_Sel = sel;
        ifb.WDSel_M = 2'($urandom_range(0, 3)); ifb.C_M = $urandom; ifb.PC8_M = $urandom;
        ifb.PC_M = $urandom;
        err = mdl_err(sz, a);
        #1;
        exp_d = (!err && rd && !wr) ? mdl_load(1, sz, sgn, a) : 32'h0;
        chk({tag, ".err"}, {31'b0, ifb.addr_err_M}, {31'b0, err});
        chk({tag, ".stall"}, {31'b0, ifb.stall_M}, 32'h0);
        chk({tag, ".d"}, ifb.D_M, exp_d);
        chk({tag, ".rfwd"}, ifb.RFWD_M, exp_rfwd(ifb.WDSel_M, ifb.C_M, exp_d, ifb.PC8_M));
        dobs = ifb.D_M;
        if (!err && wr) mdl_store(1, sz, a, sel ? rfwd : wd);
        $display("B %s rd=%0b wr=%0b sz=%0d a=%h err=%0b D_M=%h", tag, rd, wr, sz, a, err, dobs);
    endtask

    task automatic rand_op(output logic rd, output logic wr, output logic [1:0] sz,
                           output logic sgn, output logic [31:0] a);
        int op, w, off;
        op = $urandom_range(0, 7);
        rd = (op >= 3); wr = (op < 3);
        sgn = (op == 4) || (op == 6);
        case (op)
            0, 3:    sz = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
            1, 4, 5: sz = 2'b01;
            default: sz = 2'b10;
        endcase
        w = $urandom_range(0, 15);
        off = (sz == 2'b01) ? 2 * $urandom_range(0, 1) : (sz == 2'b10) ? $urandom_range(0, 3) : 0;
        if ($urandom_range(0, 7) == 0) off = $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) w = DEPTH + $urandom_range(0, 100);
        a = 32'(w * 4 + off);
    endtask

    initial begin
        logic [31:0] d, a;
        logic rd, wr, sgn;
        logic [1:0] sz;
        mdl_clear();
        ifa.MemRd_M = 0; ifa.MemWr_M = 0; ifa.MemSize_M = 0; ifa.MemSign_M = 0; ifa.A_M = 0;
        ifa.WD_M = 0; ifa.RFWD_W = 0; ifa.MF_DMWD_Sel = 0; ifa.WDSel_M = 2'b01; ifa.C_M = 0;
        ifa.PC8_M = 0; ifa.PC_M = 0;
        ifb.MemRd_M = 0; ifb.MemWr_M = 0; ifb.MemSize_M = 0; ifb.MemSign_M = 0; ifb.A_M = 0;
        ifb.WD_M = 0; ifb.RFWD_W = 0; ifb.MF_DMWD_Sel = 0; ifb.WDSel_M = 2'b01; ifb.C_M = 0;
        ifb.PC8_M = 0; ifb.PC_M = 0;
        #7;
        chk("rst.stall", {31'b0, ifa.stall_M}, 32'h0);
        chk("rst.d", ifa.D_M, 32'h0);
        chk("rst.err", {31'b0, ifa.addr_err_M}, 32'h0);
        chk("rst.rfwd", ifa.RFWD_M, 32'h0);
        #15 reset = 1'b0;

        acc_a("rst_rd", 1, 0, 2'b00, 0, 32'h3C, 32'h0, 32'h0, 0, d);
        chk("rst_rd.val", d, 32'h0);
        acc_a("sw10", 0, 1, 2'b00, 0, 32'h10, 32'h12345678, 32'hFFFF0000, 0, d);
        acc_a("lw10", 1, 0, 2'b00, 0, 32'h10, 32'h0, 32'h0, 0, d);
        chk("lw10.val", d, 32'h12345678);
        acc_a("sb13", 0, 1, 2'b10, 0, 32'h13, 32'h00000080, 32'h0, 0, d);
        acc_a("lb13", 1, 0, 2'b10, 1, 32'h13, 32'h0, 32'h0, 0, d);
        chk("lb13.val", d, 32'hFFFFFF80);
        acc_a("lbu13", 1, 0, 2'b10, 0, 32'h13, 32'h0, 32'h0, 0, d);
        chk("lbu13.val", d, 32'h00000080);
        acc_a("lw10b", 1, 0, 2'b00, 1, 32'h10, 32'h0, 32'h0, 0, d);
        chk("lw10b.val", d, 32'h80345678);
        acc_a("sh11", 0, 1, 2'b01, 0, 32'h11, 32'hBEEF, 32'h0, 0, d);
        acc_a("lw10c", 1, 0, 2'b00, 0, 32'h10, 32'h0, 32'h0, 0, d);
        chk("lw10c.val", d, 32'h80345678);
        acc_a("lw_oor", 1, 0, 2'b00, 0, 32'(DEPTH * 4), 32'h0, 32'h0, 0, d);
        acc_a("sw_fwd", 0, 1, 2'b00, 0, 32'h24, 32'h11111111, 32'hAAAA5555, 1, d);
        acc_a("lw_fwd", 1, 0, 2'b00, 0, 32'h24, 32'h0, 32'h0, 0, d);
        chk("lw_fwd.val", d, 32'hAAAA5555);
        acc_a("sh_hi", 0, 1, 2'b01, 0, 32'h26, 32'h0000C3A5, 32'h0, 0, d);
        acc_a("lh_hi", 1, 0, 2'b01, 1, 32'h26, 32'h0, 32'h0, 0, d);
        chk("lh_hi.val", d, 32'hFFFFC3A5);

        for (int i = 0; i < 60; i++) begin
            rand_op(rd, wr, sz, sgn, a);
            acc_a($sformatf("rndA%0d", i), rd, wr, sz, sgn, a, $urandom, $urandom,
                  1'($urandom_range(0, 1)), d);
        end

        // Reset in the first WAIT cycle of a store aborts it.
        @(negedge clk);
        ifa.MemWr_M = 1; ifa.MemRd_M = 0; ifa.MemSize_M = 2'b00; ifa.A_M = 32'h20;
        ifa.WD_M = 32'hDEADBEEF; ifa.MF_DMWD_Sel = 0;
        #1 chk("rstw.accept_stall", {31'b0, ifa.stall_M}, 32'h1);
        @(posedge clk);
        #1 chk("rstw.wait_stall", {31'b0, ifa.stall_M}, 32'h1);
        reset = 1'b1; ifa.MemWr_M = 0;
        #1 chk("rstw.stall", {31'b0, ifa.stall_M}, 32'h0);
        chk("rstw.d", ifa.D_M, 32'h0);
        #1 reset = 1'b0;
        mdl_clear();
        #1 chk("rstw.post_stall", {31'b0, ifa.stall_M}, 32'h0);
        acc_a("rstw_lw", 1, 0, 2'b00, 0, 32'h20, 32'h0, 32'h0, 0, d);
        chk("rstw_lw.val", d, 32'h0);

        acc_b("b_sw", 0, 1, 2'b00, 0, 32'h8, 32'hCAFEF00D, 32'h0, 0, d);
        acc_b("b_lw", 1, 0, 2'b00, 0, 32'h8, 32'h0, 32'h0, 0, d);
        chk("b_lw.val", d, 32'hCAFEF00D);
        for (int i = 0; i < 50; i++) begin
            rand_op(rd, wr, sz, sgn, a);
            acc_b($sformatf("rndB%0d", i), rd, wr, sz, sgn, a, $urandom, $urandom,
                  1'($urandom_range(0, 1)), d);
        end
        @(negedge clk);
        ifb.MemRd_M = 0; ifb.MemWr_M = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stage_m_mc.md
STAGE_M_MC -- requirements
Module: stage_m_mc

Interface
REQ-001 Parameter DEPTH, default 1024, data-memory size in 32-bit words; power of two, 16..4096.
REQ-002 Parameter LAT, default 2, memory access latency in cycles; legal range 0..7.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 PC_M  in  32  PC of the instruction in M; pass-through for trace only.
REQ-006 MemRd_M  in  1  load request.
REQ-007 MemWr_M  in  1  store request; MemRd_M and MemWr_M both high is illegal.
REQ-008 MemSize_M  in  2  00 word, 01 half, 10 byte, 11 reserved and treated as word.
REQ-009 MemSign_M  in  1  1 sign-extends loads, 0 zero-extends them.
REQ-010 A_M  in  32  byte address.
REQ-011 WD_M  in  32  store data from the pipeline register.
REQ-012 RFWD_W  in  32  W-stage forwarded value.
REQ-013 MF_DMWD_Sel  in  1  1 selects RFWD_W as store data, 0 selects WD_M.
REQ-014 WDSel_M  in  2  00 C_M, 01 D_M, 10 PC8_M, 11 zero.
REQ-015 C_M  in  32  ALU result.
REQ-016 PC8_M  in  32  link value.
REQ-017 D_M  out  32  extended load data.
REQ-018 RFWD_M  out  32  selected M-stage writeback value.
REQ-019 stall_M  out  1  freezes F/D/E/M registers and bubbles W.
REQ-020 addr_err_M  out  1  misaligned or out-of-range access.

Function
REQ-021 A request is MemRd_M or MemWr_M high while the FSM is in IDLE.
REQ-022 Error check: a word access with A_M[1:0]!=0, a half access with A_M[0]=1, or A_M[31:2]>=DEPTH sets addr_err_M combinationally; the access is dropped, memory is unchanged, stall_M stays 0 and D_M=0.
REQ-023 The FSM has three states: IDLE, WAIT and DONE.
REQ-024 LAT=0: a legal request completes in IDLE; the store commits on that edge, load data is combinational, and stall_M=0.
REQ-025 LAT>0: a legal request in cycle t latches the word address, byte offset, size, sign, direction and store data (after the MF_DMWD_Sel mux), loads counter=LAT-1, and enters WAIT.
REQ-026 stall_M is high combinationally in cycle t and in every WAIT cycle.
REQ-027 WAIT decrements the counter each cycle and goes to DONE when counter==0; stall_M is therefore high for exactly LAT cycles (t..t+LAT-1).
REQ-028 DONE lasts cycle t+LAT with stall_M=0: a load drives D_M from latched operands, and a store commits at the rising edge that ends t+LAT.
REQ-029 DONE always returns to IDLE; a new request is sampled no earlier than t+LAT+1, so back-to-back accesses cost LAT+1 cycles each.
REQ-030 Latched operands are used through WAIT/DONE; changes on RFWD_W, A_M or WD_M during stall have no effect.
REQ-031 Store byte enables: word writes all 4 bytes; half writes bytes {1,0} if A[1]=0, else {3,2}, using WD[15:0]; byte writes byte A[1:0] using WD[7:0].
REQ-032 Unwritten bytes retain their previous value.
REQ-033 Load extraction selects the same lanes as stores; half/byte results are sign- or zero-extended to 32 bits per MemSign_M; a word load ignores MemSign_M.
REQ-034 D_M=0 whenever no load completes this cycle.
REQ-035 RFWD_M follows REQ-014 combinationally.
REQ-036 A store to word X followed by a load of word X observes the stored data (no stale read).
REQ-037 The simultaneous MemRd_M/MemWr_M case is treated as a store; this keeps synthesis defined, but the input remains illegal.

Reset
REQ-038 On reset: FSM=IDLE, counter=0, latches=0, all DEPTH words=0, stall_M=0, D_M=0, addr_err_M=0.
REQ-039 A reset asserted during WAIT or DONE aborts the access with no memory write; after release the block is in IDLE and accepts a request on the first clock edge.

Verification
REQ-040 LAT=2: sw A=0x10, data 0x12345678, then lw A=0x10 -> stall_M high 2 cycles for each; D_M=0x12345678 in the load's DONE cycle.
REQ-041 LAT=2: sb 0x80 at A=0x13, then lb and lbu at A=0x13 -> lb returns 0xFFFFFF80, lbu returns 0x00000080; the word at 0x10 reads 0x80345678.
REQ-042 sh at A=0x11 -> addr_err_M=1, stall_M=0, and the word at 0x10 is unchanged; lw at A=DEPTH*4 -> addr_err_M=1, D_M=0.
REQ-043 MF_DMWD_Sel=1, RFWD_W=0xAAAA5555 at acceptance, then RFWD_W=0 during WAIT -> memory holds 0xAAAA5555.
REQ-044 reset pulsed in the first WAIT cycle of sw 0xDEADBEEF -> after release, stall_M=0 and lw of that address returns 0.
REQ-045 LAT=0: sw then lw on consecutive cycles -> stall_M never asserts, and the load returns the stored value.
